sram_sync: RTL and testbench

- Clocked, parametrised successor to the asynchronous 6116-style SRAM model used for CPU work RAM in the piano emulation.
- Keeps the active-low WE/OE bus semantics but actually commits writes, on the rising edge of write-enable.
- Adds a power-on clear sequencer and a second read-only debug/dump port for test benches and state inspection.
- Sits between the MCU bus decode and any logic that needs RAM contents. Tristating is done at the top level; this block only outputs a drive-enable.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_array.sv | 47 ++++
 rtl/sram_sync.sv | 258 +++++++++++++++++++++++++
 tb/tb_sram_sync.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the synchronous work RAM
package sram_pkg;

    // Sequencer states: CLEAR sweeps INIT_VALUE through the array, IDLE serves the bus
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Where a registered read word comes from: nothing yet, the fill value, or the array
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_INIT = 2'd1,
        SRC_MEM  = 2'd2
    } rd_src_t;

    // True when a word address lands inside the populated part of the address space
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - one write port, two registered read ports, read-before-write
module sram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int RAM_DEPTH  = 2048
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic                  i_re_b,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata_a;
    logic [DATA_WIDTH-1:0] r_rdata_b;

    // Write port; the non-blocking update means same-edge reads see the old word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port A; output register holds its value while not enabled
    always_ff @(posedge clk) begin
        if (i_re_a) begin
            r_rdata_a <= r_mem[i_raddr_a];
        end
    end

    // Read port B; output register holds its value while not enabled
    always_ff @(posedge clk) begin
        if (i_re_b) begin
            r_rdata_b <= r_mem[i_raddr_b];
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/sram_sync.sv
// rtl/sram_sync.sv - clocked 6116-style work RAM with power-on clear and debug read port
module sram_sync
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    RAM_DEPTH      = 2048,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_cs_n,
    input  logic                  bus_we_n,
    input  logic                  bus_oe_n,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_address,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  busy,
    output logic                  write_dropped
);

    localparam int     IDX_W       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int     PTR_W       = ADDR_WIDTH + 1;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } rd_stage_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PTR_W-1:0]      r_ptr;
    logic                  w_ptr_last;
    logic                  w_busy;
    logic                  w_clear_we;

    logic                  r_we_n_prev;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  w_commit;
    logic                  w_pend_in_range;
    logic                  r_write_dropped;

    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    logic                  w_bus_re;
    logic                  w_bus_mem_re;
    logic                  r_bus_v1;
    rd_src_t               r_bus_src;
    logic [DATA_WIDTH-1:0] w_rdata_a;
    rd_stage_t             w_stage1;

    logic                  w_dbg_re;
    logic                  w_dbg_mem_re;
    logic                  r_dbg_valid;
    rd_src_t               r_dbg_src;
    logic [DATA_WIDTH-1:0] w_rdata_b;
    logic [DATA_WIDTH-1:0] w_dbg_data;

    // Sequencer state register; reset restarts the clear sweep from scratch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave CLEAR right after the last word has been written
    always_comb begin
        w_state_next = r_state;
        if (r_state == CLEAR && w_ptr_last) begin
            w_state_next = IDLE;
        end
    end

    // Sequencer outputs: busy flag and clear write strobe
    always_comb begin
        w_busy     = 1'b0;
        w_clear_we = 1'b0;
        if (r_state == CLEAR) begin
            w_busy     = 1'b1;
            w_clear_we = 1'b1;
        end
    end

    assign w_ptr_last = (r_ptr == PTR_W'(RAM_DEPTH - 1));

    // Clear pointer; one extra bit so a full 2**ADDR_WIDTH sweep never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_clear_we) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    // we_n history for rising-edge commit detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_n_prev <= 1'b1;
        end else begin
            r_we_n_prev <= bus_we_n;
        end
    end

    // Pending write capture while selected and write-enabled; the last cycle wins
    always_ff @(posedge clk) begin
        if (!bus_cs_n && !bus_we_n) begin
            r_pend_addr <= bus_address;
            r_pend_data <= bus_data_in;
        end
    end

    assign w_commit        = !r_we_n_prev && bus_we_n;
    assign w_pend_in_range = addr_in_range(32'(r_pend_addr), 32'(RAM_DEPTH));

    // Single array write port shared by the clear sweep and bus commits
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_pend_addr[IDX_W-1:0];
        w_wr_data = r_pend_data;
        if (w_clear_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr[IDX_W-1:0];
            w_wr_data = INIT_VALUE;
        end else if (w_commit && w_pend_in_range) begin
            w_wr_en   = 1'b1;
        end
    end

    // Flag commits that land during the clear sweep or outside the array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_dropped <= 1'b0;
        end else begin
            r_write_dropped <= w_commit && (r_state == CLEAR || !w_pend_in_range);
        end
    end

    assign w_bus_re     = !bus_cs_n && !bus_oe_n && bus_we_n;
    assign w_bus_mem_re = w_bus_re && (r_state == IDLE)
                          && addr_in_range(32'(bus_address), 32'(RAM_DEPTH));
    assign w_dbg_re     = dbg_req && (r_state == IDLE);
    assign w_dbg_mem_re = w_dbg_re && addr_in_range(32'(dbg_address), 32'(RAM_DEPTH));

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (IDX_W),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_array (
        .clk        (clk),
        .i_we       (w_wr_en),
        .i_waddr    (w_wr_addr),
        .i_wdata    (w_wr_data),
        .i_re_a     (w_bus_mem_re),
        .i_raddr_a  (bus_address[IDX_W-1:0]),
        .o_rdata_a  (w_rdata_a),
        .i_re_b     (w_dbg_mem_re),
        .i_raddr_b  (dbg_address[IDX_W-1:0]),
        .o_rdata_b  (w_rdata_b)
    );

    // First bus read stage: valid flag plus which source the array register stands for
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_v1  <= 1'b0;
            r_bus_src <= SRC_ZERO;
        end else begin
            r_bus_v1 <= w_bus_re;
            if (w_bus_re) begin
                r_bus_src <= w_bus_mem_re ? SRC_MEM : SRC_INIT;
            end
        end
    end

    // Resolve the first stage word; fill value covers clear and out-of-range reads
    always_comb begin
        w_stage1       = '0;
        w_stage1.valid = r_bus_v1;
        case (r_bus_src)
            SRC_MEM:  w_stage1.data = w_rdata_a;
            SRC_INIT: w_stage1.data = INIT_VALUE;
            default:  w_stage1.data = '0;
        endcase
    end

    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            assign bus_data_out = w_stage1.data;
            assign bus_data_oe  = w_stage1.valid;
        end else begin : g_pipe
            rd_stage_t r_pipe [READ_LATENCY-1];

            // Delay line; data only advances with a valid beat so the bus value holds between reads
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < READ_LATENCY - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0].valid <= w_stage1.valid;
                    if (w_stage1.valid) begin
                        r_pipe[0].data <= w_stage1.data;
                    end
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        r_pipe[i].valid <= r_pipe[i-1].valid;
                        if (r_pipe[i-1].valid) begin
                            r_pipe[i].data <= r_pipe[i-1].data;
                        end
                    end
                end
            end

            assign bus_data_out = r_pipe[READ_LATENCY-2].data;
            assign bus_data_oe  = r_pipe[READ_LATENCY-2].valid;
        end
    endgenerate

    // Debug read tracking: one-cycle valid pulse and source of the held word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbg_valid <= 1'b0;
            r_dbg_src   <= SRC_ZERO;
        end else begin
            r_dbg_valid <= w_dbg_re;
            if (w_dbg_re) begin
                r_dbg_src <= w_dbg_mem_re ? SRC_MEM : SRC_INIT;
            end
        end
    end

    // Resolve the debug word from its recorded source
    always_comb begin
        w_dbg_data = '0;
        case (r_dbg_src)
            SRC_MEM:  w_dbg_data = w_rdata_b;
            SRC_INIT: w_dbg_data = INIT_VALUE;
            default:  w_dbg_data = '0;
        endcase
    end

    assign dbg_valid     = r_dbg_valid;
    assign dbg_data      = w_dbg_data;
    assign busy          = w_busy;
    assign write_dropped = r_write_dropped;

endmodule

// File: tb/tb_sram_sync.sv
// tb/tb_sram_sync.sv - self-checking bench for sram_sync
module tb_sram_sync;

    localparam int         DW    = 8;
    localparam int         AW    = 12;
    localparam int         DEPTH = 2048;
    localparam int         LAT   = 2;
    localparam logic [7:0] INIT  = 8'h00;

    logic          clk;
    logic          reset;
    logic          bus_cs_n;
    logic          bus_we_n;
    logic          bus_oe_n;
    logic [AW-1:0] bus_address;
    logic [DW-1:0] bus_data_in;
    logic [DW-1:0] bus_data_out;
    logic          bus_data_oe;
    logic          dbg_req;
    logic [AW-1:0] dbg_address;
    logic          dbg_valid;
    logic [DW-1:0] dbg_data;
    logic          busy;
    logic          write_dropped;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_mem [DEPTH];

    sram_sync #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .RAM_DEPTH      (DEPTH),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1),
        .INIT_VALUE     (INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_cs_n      (bus_cs_n),
        .bus_we_n      (bus_we_n),
        .bus_oe_n      (bus_oe_n),
        .bus_address   (bus_address),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .bus_data_oe   (bus_data_oe),
        .dbg_req       (dbg_req),
        .dbg_address   (dbg_address),
        .dbg_valid     (dbg_valid),
        .dbg_data      (dbg_data),
        .busy          (busy),
        .write_dropped (write_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_cs_n    = 1'b1;
        bus_we_n    = 1'b1;
        bus_oe_n    = 1'b1;
        bus_address = '0;
        bus_data_in = '0;
        dbg_req     = 1'b0;
        dbg_address = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic dbg_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
        dbg_req     = 1'b1;
        dbg_address = a;
        tick();
        v = dbg_valid;
        d = dbg_data;
        dbg_req = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_cs_n    = 1'b0;
        bus_we_n    = 1'b0;
        bus_address = a;
        bus_data_in = d;
        tick();
        bus_we_n = 1'b1;
        bus_cs_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int            n;
        logic          v;
        logic [DW-1:0] d;
        logic [AW-1:0] addrs [3];
        reset = 1'b1;
        idle_inputs();
        tick();
        n_assert++;
        if ({bus_data_out, dbg_data, bus_data_oe, dbg_valid, write_dropped, busy} !== {8'h00, 8'h00, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_values: got out=%h dbg=%h oe=%b dv=%b drop=%b busy=%b, want 00 00 0 0 0 1",
                     bus_data_out, dbg_data, bus_data_oe, dbg_valid, write_dropped, busy);
        end
        tick();
        reset = 1'b0;
        count_busy(n);
        n_assert++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL clear_length: busy for %0d cycles, want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
        addrs[0] = 12'd0;
        addrs[1] = 12'd1023;
        addrs[2] = 12'd2047;
        for (int i = 0; i < 3; i++) begin
            dbg_read(addrs[i], v, d);
            n_assert++;
            if (v !== 1'b1 || d !== INIT) begin
                n_fail++;
                $display("FAIL clear_dbg_%0d: valid=%b data=%h, want 1 %h", addrs[i], v, d, INIT);
            end
        end
    endtask

    task automatic test_write_capture();
        logic [DW-1:0] seq [3];
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h5A;
        bus_cs_n    = 1'b0;
        bus_address = 12'h123;
        for (int i = 0; i < 3; i++) begin
            bus_we_n    = 1'b0;
            bus_data_in = seq[i];
            tick();
        end
        bus_we_n = 1'b1;
        tick();
        m_mem[12'h123] = 8'h5A;
        bus_oe_n = 1'b0;
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency_early: oe=%b one cycle after oe_n fell, want 0", bus_data_oe);
        end
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b1 || bus_data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_last_wins: oe=%b data=%h, want 1 5a", bus_data_oe, bus_data_out);
        end
        bus_oe_n = 1'b1;
        bus_cs_n = 1'b1;
        tick();
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b0 || bus_data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_hold: oe=%b data=%h, want 0 5a", bus_data_oe, bus_data_out);
        end
    endtask

    task automatic test_read_before_write();
        logic          v;
        logic [DW-1:0] d;
        bus_cs_n    = 1'b0;
        bus_we_n    = 1'b0;
        bus_address = 12'h040;
        bus_data_in = 8'hA5;
        tick();
        bus_we_n = 1'b1;
        bus_cs_n = 1'b1;
        dbg_read(12'h040, v, d);
        n_assert++;
        if (v !== 1'b1 || d !== 8'h00) begin
            n_fail++;
            $display("FAIL rbw_old: valid=%b data=%h, want 1 00", v, d);
        end
        m_mem[12'h040] = 8'hA5;
        dbg_read(12'h040, v, d);
        n_assert++;
        if (v !== 1'b1 || d !== 8'hA5) begin
            n_fail++;
            $display("FAIL rbw_new: valid=%b data=%h, want 1 a5", v, d);
        end
    endtask

    task automatic test_out_of_range();
        logic          v;
        logic [DW-1:0] d;
        bus_write(12'd2050, 8'h77);
        n_assert++;
        if (write_dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_drop: write_dropped=%b, want 1", write_dropped);
        end
        tick();
        n_assert++;
        if (write_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_drop_pulse: write_dropped=%b one cycle later, want 0", write_dropped);
        end
        bus_cs_n    = 1'b0;
        bus_oe_n    = 1'b0;
        bus_address = 12'h123;
        tick();
        bus_address = 12'd2050;
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b1 || bus_data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL b2b_read_first: oe=%b data=%h, want 1 5a", bus_data_oe, bus_data_out);
        end
        bus_oe_n = 1'b1;
        bus_cs_n = 1'b1;
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b1 || bus_data_out !== INIT) begin
            n_fail++;
            $display("FAIL oob_read: oe=%b data=%h, want 1 %h", bus_data_oe, bus_data_out, INIT);
        end
        dbg_read(12'd2, v, d);
        n_assert++;
        if (v !== 1'b1 || d !== m_mem[2]) begin
            n_fail++;
            $display("FAIL oob_alias: mem[2] valid=%b data=%h, want 1 %h", v, d, m_mem[2]);
        end
        bus_cs_n    = 1'b0;
        bus_oe_n    = 1'b0;
        bus_address = 12'h123;
        tick();
        bus_oe_n = 1'b1;
        bus_cs_n = 1'b1;
        tick();
        tick();
        dbg_read(12'h040, v, d);
    endtask

    task automatic test_reset_midclear();
        int            n;
        int            bad;
        logic          v;
        logic [DW-1:0] d;
        reset = 1'b1;
        #1;
        n_assert++;
        if ({bus_data_out, dbg_data, bus_data_oe, dbg_valid, busy} !== {8'h00, 8'h00, 3'b001}) begin
            n_fail++;
            $display("FAIL async_reset: out=%h dbg=%h oe=%b dv=%b busy=%b, want 00 00 0 0 1",
                     bus_data_out, dbg_data, bus_data_oe, dbg_valid, busy);
        end
        tick();
        reset = 1'b0;
        bus_write(12'd5, 8'h33);
        n_assert++;
        if (write_dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_drop: write_dropped=%b, want 1", write_dropped);
        end
        dbg_read(12'd7, v, d);
        n_assert++;
        if (v !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_dbg_ignored: dbg_valid=%b, want 0", v);
        end
        bus_cs_n    = 1'b0;
        bus_oe_n    = 1'b0;
        bus_address = 12'h010;
        tick();
        bus_oe_n = 1'b1;
        bus_cs_n = 1'b1;
        tick();
        n_assert++;
        if (bus_data_oe !== 1'b1 || bus_data_out !== INIT) begin
            n_fail++;
            $display("FAIL clear_bus_read: oe=%b data=%h, want 1 %h", bus_data_oe, bus_data_out, INIT);
        end
        bad = 0;
        for (int i = 6; i < 1000; i++) begin
            if (busy !== 1'b1) bad++;
            tick();
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_busy_hold: busy low in %0d cycles, want 0", bad);
        end
        reset = 1'b1;
        tick();
        tick();
        n_assert++;
        if ({busy, bus_data_oe, dbg_valid, write_dropped, bus_data_out} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL midclear_reset: busy=%b oe=%b dv=%b drop=%b out=%h, want 1 0 0 0 00",
                     busy, bus_data_oe, dbg_valid, write_dropped, bus_data_out);
        end
        reset = 1'b0;
        count_busy(n);
        n_assert++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL restart_length: busy for %0d cycles, want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
        dbg_read(12'd5, v, d);
        n_assert++;
        if (v !== 1'b1 || d !== INIT) begin
            n_fail++;
            $display("FAIL clear_write_discarded: mem[5] valid=%b data=%h, want 1 %h", v, d, INIT);
        end
        dbg_read(12'h123, v, d);
        n_assert++;
        if (v !== 1'b1 || d !== INIT) begin
            n_fail++;
            $display("FAIL reclear: mem[123] valid=%b data=%h, want 1 %h", v, d, INIT);
        end
    endtask

    task automatic test_random();
        logic          prev_we;
        logic [AW-1:0] pend_a;
        logic [DW-1:0] pend_d;
        logic [DW-1:0] exp_bus;
        logic [DW-1:0] exp_dbg;
        logic          exp_oe;
        logic          exp_dv;
        logic          exp_drop;
        logic [DW-1:0] rd_word;
        logic          q_v [$];
        logic [DW-1:0] q_d [$];
        logic          cs;
        logic          we;
        logic          oe;
        logic [AW-1:0] a;
        int            r;
        prev_we = 1'b1;
        pend_a  = '0;
        pend_d  = '0;
        exp_bus = 8'h00;
        exp_dbg = 8'h00;
        for (int i = 0; i < LAT - 1; i++) begin
            q_v.push_back(1'b0);
            q_d.push_back(8'h00);
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            cs = ($urandom_range(0, 9) == 0);
            if (!prev_we) we = ($urandom_range(0, 2) == 0);
            else          we = !(!cs && $urandom_range(0, 3) == 0);
            oe = $urandom_range(0, 1) == 1;
            r  = $urandom_range(0, 9);
            if (r < 7)      a = AW'($urandom_range(0, 31));
            else if (r < 9) a = AW'($urandom_range(2040, 2060));
            else            a = AW'($urandom_range(0, 4095));
            bus_cs_n    = cs;
            bus_we_n    = we;
            bus_oe_n    = oe;
            bus_address = a;
            bus_data_in = DW'($urandom);
            dbg_req     = $urandom_range(0, 1) == 1;
            dbg_address = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                      : AW'($urandom_range(0, 31));
            rd_word = (a < DEPTH) ? m_mem[a] : INIT;
            q_v.push_back(!cs && !oe && we);
            q_d.push_back(rd_word);
            exp_oe = q_v.pop_front();
            rd_word = q_d.pop_front();
            if (exp_oe) exp_bus = rd_word;
            exp_dv = dbg_req;
            if (dbg_req) exp_dbg = m_mem[dbg_address];
            exp_drop = 1'b0;
            if (!prev_we && we) begin
                if (pend_a < DEPTH) m_mem[pend_a] = pend_d;
                else                exp_drop = 1'b1;
            end
            if (!cs && !we) begin
                pend_a = a;
                pend_d = bus_data_in;
            end
            prev_we = we;
            tick();
            n_assert++;
            if ($isunknown({bus_data_out, bus_data_oe, dbg_valid, dbg_data, busy, write_dropped})) begin
                n_fail++;
                $display("FAIL rand_xz cycle %0d: out=%h oe=%b dv=%b dbg=%h busy=%b drop=%b",
                         cyc, bus_data_out, bus_data_oe, dbg_valid, dbg_data, busy, write_dropped);
            end
            n_assert++;
            if (bus_data_oe !== exp_oe || bus_data_out !== exp_bus) begin
                n_fail++;
                $display("FAIL rand_bus cycle %0d: oe=%b data=%h, want %b %h",
                         cyc, bus_data_oe, bus_data_out, exp_oe, exp_bus);
            end
            n_assert++;
            if (dbg_valid !== exp_dv || dbg_data !== exp_dbg) begin
                n_fail++;
                $display("FAIL rand_dbg cycle %0d: valid=%b data=%h, want %b %h",
                         cyc, dbg_valid, dbg_data, exp_dv, exp_dbg);
            end
            n_assert++;
            if (write_dropped !== exp_drop || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_flags cycle %0d: drop=%b busy=%b, want %b 0",
                         cyc, write_dropped, busy, exp_drop);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_capture();
        test_read_before_write();
        test_out_of_range();
        test_reset_midclear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
